pwm_button_conditioner: RTL and testbench

- Upstream front end for the PWM generator's duty selector counter.
- Takes the two raw, active-low, bouncing push-buttons (sum = increase duty reference, rest = decrease duty reference).
- Per button: synchronises, debounces, converts a press into a single-cycle active-high step pulse, and auto-repeats while the button is held.
- The step pulses drive the selector counter's increment/decrement controls directly.

---
 rtl/pwm_button_conditioner_pkg.sv | 21 ++
 rtl/button_channel.sv | 120 ++++++++++++
 rtl/pwm_button_conditioner.sv | 85 ++++++++
 tb/tb_pwm_button_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_button_conditioner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pwm_button_conditioner_pkg
// Brief    : Shared state encoding and counter width helper for the
//            button conditioner.
// Revision : 1.0
// ----------------------------------------------------------------------------
package pwm_button_conditioner_pkg;

  localparam logic [1:0] c_st_idle       = 2'd0;
  localparam logic [1:0] c_st_wait_delay = 2'd1;
  localparam logic [1:0] c_st_repeat     = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    if (max_val <= 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : button_channel
// Brief    : Synchroniser, debouncer and press/auto-repeat FSM for one
//            active-low push-button.
// Revision : 1.0
// ----------------------------------------------------------------------------
module button_channel
  import pwm_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pulse_raw,
  output logic held
);

  localparam int c_db_w      = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int c_rep_max   = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int c_rep_w     = cnt_width(c_rep_max);
  localparam logic [c_db_w-1:0]  c_db_last     = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
  localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [c_db_w-1:0]  r_db_cnt;
  logic [1:0]         r_state;
  logic [c_rep_w-1:0] r_rep_cnt;
  logic [1:0]         w_next_state;
  logic [c_rep_w-1:0] w_next_cnt;
  logic               w_pulse;
  logic               w_pressed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_stable <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_pressed = ~r_stable;

  // Pulse is decided combinationally so the top's output register lands it
  // one edge after the stable press.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_rep_cnt;
    w_pulse      = 1'b0;
    if (!w_pressed) begin
      w_next_state = c_st_idle;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_pulse      = 1'b1;
          w_next_cnt   = '0;
          w_next_state = c_st_wait_delay;
        end
        c_st_wait_delay: begin
          if (REPEAT_EN != 0) begin
            if (r_rep_cnt == c_delay_last) begin
              w_pulse      = 1'b1;
              w_next_cnt   = '0;
              w_next_state = c_st_repeat;
            end else begin
              w_next_cnt = r_rep_cnt + 1'b1;
            end
          end
        end
        c_st_repeat: begin
          if (r_rep_cnt == c_period_last) begin
            w_pulse    = 1'b1;
            w_next_cnt = '0;
          end else begin
            w_next_cnt = r_rep_cnt + 1'b1;
          end
        end
        default: begin
          w_next_state = c_st_idle;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_st_idle;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_rep_cnt <= w_next_cnt;
    end
  end

  assign pulse_raw = w_pulse;
  assign held      = w_pressed;

endmodule
`default_nettype wire

// File: rtl/pwm_button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pwm_button_conditioner
// Brief    : Two conditioned buttons producing increment/decrement step
//            pulses, with both pulses suppressed while both are pressed.
// Revision : 1.0
// ----------------------------------------------------------------------------
module pwm_button_conditioner
  import pwm_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sum,
  input  logic rest,
  output logic sum_pulse,
  output logic rest_pulse,
  output logic sum_held,
  output logic rest_held
);

  logic w_sum_pulse_raw;
  logic w_rest_pulse_raw;
  logic w_sum_held;
  logic w_rest_held;
  logic w_conflict;
  logic r_sum_pulse;
  logic r_rest_pulse;
  logic r_sum_held;
  logic r_rest_held;

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_sum_channel (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (sum),
    .pulse_raw (w_sum_pulse_raw),
    .held      (w_sum_held)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_rest_channel (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (rest),
    .pulse_raw (w_rest_pulse_raw),
    .held      (w_rest_held)
  );

  // Channels keep counting through a conflict; only the outputs are masked.
  assign w_conflict = w_sum_held & w_rest_held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum_pulse  <= 1'b0;
      r_rest_pulse <= 1'b0;
      r_sum_held   <= 1'b0;
      r_rest_held  <= 1'b0;
    end else begin
      r_sum_pulse  <= w_sum_pulse_raw & ~w_conflict;
      r_rest_pulse <= w_rest_pulse_raw & ~w_conflict;
      r_sum_held   <= w_sum_held;
      r_rest_held  <= w_rest_held;
    end
  end

  assign sum_pulse  = r_sum_pulse;
  assign rest_pulse = r_rest_pulse;
  assign sum_held   = r_sum_held;
  assign rest_held  = r_rest_held;

endmodule
`default_nettype wire

// File: tb/tb_pwm_button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pwm_button_conditioner
// Brief    : Directed and random stimulus for two conditioner instances
//            (auto-repeat on and off) against an event-time reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_pwm_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 10;
  localparam int HL = DB + 2;

  logic clk = 1'b0;
  logic rst;
  logic sum;
  logic rest;
  logic sum_pulse, rest_pulse, sum_held, rest_held;
  logic nr_sum_pulse, nr_rest_pulse, nr_sum_held, nr_rest_held;

  always #5 clk = ~clk;

  pwm_button_conditioner #(
    .DEBOUNCE_CYCLES (DB), .REPEAT_EN (1), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
  ) u_dut (
    .clk (clk), .rst (rst), .sum (sum), .rest (rest),
    .sum_pulse (sum_pulse), .rest_pulse (rest_pulse),
    .sum_held (sum_held), .rest_held (rest_held)
  );

  pwm_button_conditioner #(
    .DEBOUNCE_CYCLES (DB), .REPEAT_EN (0), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
  ) u_dut_nr (
    .clk (clk), .rst (rst), .sum (sum), .rest (rest),
    .sum_pulse (nr_sum_pulse), .rest_pulse (nr_rest_pulse),
    .sum_held (nr_sum_held), .rest_held (nr_rest_held)
  );

  // Reference model: a level is accepted once the last DB synchronised
  // samples all disagree with it; pulses are scheduled by elapsed time
  // since the accepted press.
  logic hist [0:1][0:HL-1];
  logic stable [0:1];
  int   tp [0:1];
  int   edge_n = 0;
  logic exp_pulse [0:1];
  logic exp_nr_pulse [0:1];
  logic exp_held [0:1];

  always begin : p_model
    logic conflict;
    logic all_diff;
    logic raw [0:1];
    int   k;
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        stable[c]       = 1'b1;
        tp[c]           = 0;
        exp_pulse[c]    = 1'b0;
        exp_nr_pulse[c] = 1'b0;
        exp_held[c]     = 1'b0;
        for (int i = 0; i < HL; i++) hist[c][i] = 1'b1;
      end
    end else begin
      edge_n++;
      conflict = !stable[0] && !stable[1];
      raw[0] = sum;
      raw[1] = rest;
      for (int c = 0; c < 2; c++) begin
        exp_held[c] = !stable[c];
        if (!stable[c]) begin
          k = edge_n - 1 - tp[c];
          exp_pulse[c]    = ((k == 0) || (k >= RD && ((k - RD) % RP) == 0)) && !conflict;
          exp_nr_pulse[c] = (k == 0) && !conflict;
        end else begin
          exp_pulse[c]    = 1'b0;
          exp_nr_pulse[c] = 1'b0;
        end
        for (int i = 0; i < HL - 1; i++) hist[c][i] = hist[c][i+1];
        hist[c][HL-1] = raw[c];
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[c][i] == stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          stable[c] = !stable[c];
          if (!stable[c]) tp[c] = edge_n;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int step_idx;
  int cnt_sum, cnt_rest, cnt_sum_nr, cnt_rest_nr, first_sum;
  int sum_at [0:15];
  logic rest_held_seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, step_idx, act, exp);
    end
  endtask

  task automatic clear_counts();
    step_idx = 0; cnt_sum = 0; cnt_rest = 0; cnt_sum_nr = 0; cnt_rest_nr = 0;
    first_sum = -1; rest_held_seen = 1'b0;
    for (int i = 0; i < 16; i++) sum_at[i] = -1;
  endtask

  // Advance n cycles, comparing every output against the model each cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_idx++;
      check("sum_pulse",     sum_pulse,     exp_pulse[0]);
      check("rest_pulse",    rest_pulse,    exp_pulse[1]);
      check("sum_held",      sum_held,      exp_held[0]);
      check("rest_held",     rest_held,     exp_held[1]);
      check("nr_sum_pulse",  nr_sum_pulse,  exp_nr_pulse[0]);
      check("nr_rest_pulse", nr_rest_pulse, exp_nr_pulse[1]);
      check("nr_sum_held",   nr_sum_held,   exp_held[0]);
      check("nr_rest_held",  nr_rest_held,  exp_held[1]);
      if (sum_pulse) begin
        if (cnt_sum < 16) sum_at[cnt_sum] = step_idx;
        cnt_sum++;
        if (first_sum < 0) first_sum = step_idx;
      end
      if (rest_pulse)    cnt_rest++;
      if (nr_sum_pulse)  cnt_sum_nr++;
      if (nr_rest_pulse) cnt_rest_nr++;
      if (rest_held)     rest_held_seen = 1'b1;
    end
  endtask

  initial begin : p_stim
    int dur [0:1];
    rst = 1'b0; sum = 1'b1; rest = 1'b1;
    clear_counts();
    step(3);
    check("reset_sum_pulse",  sum_pulse,  0);
    check("reset_rest_pulse", rest_pulse, 0);
    check("reset_sum_held",   sum_held,   0);
    check("reset_rest_held",  rest_held,  0);
    #2 rst = 1'b1;
    step(5);

    // Clean press held 50 cycles.
    clear_counts();
    sum = 1'b0; step(50);
    check("clean_held", sum_held, 1);
    sum = 1'b1; step(20);
    check("clean_first_pulse", first_sum, DB + 3);
    check("clean_nr_count", cnt_sum_nr, 1);
    check("clean_rep_count", cnt_sum, 4);
    check("clean_rest_count", cnt_rest, 0);
    check("clean_released", sum_held, 0);

    // Bouncing rest button.
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      rest = 1'b0; step(2);
      rest = 1'b1; step(2);
    end
    step(20);
    check("bounce_rest_count", cnt_rest, 0);
    check("bounce_rest_held", int'(rest_held_seen), 0);

    // Auto-repeat over a 60-cycle hold.
    clear_counts();
    sum = 1'b0; step(60);
    sum = 1'b1; step(20);
    check("repeat_count", cnt_sum, 5);
    check("repeat_p0", sum_at[0], 7);
    check("repeat_p1", sum_at[1], 27);
    check("repeat_p2", sum_at[2], 37);
    check("repeat_p4", sum_at[4], 57);

    // Both pressed: everything masked, then sum resumes on schedule.
    clear_counts();
    sum = 1'b0; rest = 1'b0; step(100);
    check("conflict_sum_count", cnt_sum, 0);
    check("conflict_rest_count", cnt_rest, 0);
    check("conflict_sum_held", sum_held, 1);
    check("conflict_rest_held", rest_held, 1);
    rest = 1'b1; step(40);
    sum = 1'b1; step(20);
    check("resume_count", cnt_sum, 4);
    check("resume_first", sum_at[0], 107);
    check("resume_nr_count", cnt_sum_nr, 0);

    // Reset pulled low mid-hold.
    clear_counts();
    sum = 1'b0; step(40);
    check("prereset_held", sum_held, 1);
    #2 rst = 1'b0;
    #1;
    check("midreset_sum_held",  sum_held,  0);
    check("midreset_sum_pulse", sum_pulse, 0);
    check("midreset_rest_held", rest_held, 0);
    step(1);
    #2 rst = 1'b1;
    clear_counts();
    step(20);
    check("postreset_first", first_sum, DB + 3);
    sum = 1'b1; step(20);

    // Glitch one short of the debounce time, then an exact-length press.
    clear_counts();
    sum = 1'b0; step(DB - 1);
    sum = 1'b1; step(20);
    check("glitch_count", cnt_sum, 0);
    check("glitch_nr_count", cnt_sum_nr, 0);
    clear_counts();
    sum = 1'b0; step(DB);
    sum = 1'b1; step(20);
    check("short_count", cnt_sum, 1);
    check("short_nr_count", cnt_sum_nr, 1);
    check("short_first", first_sum, DB + 3);

    // Random press/release traffic on both buttons.
    clear_counts();
    dur[0] = 0; dur[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (dur[c] == 0) begin
          if (c == 0) sum = ~sum; else rest = ~rest;
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 70))
                                                : int'($urandom_range(1, 8));
        end
        dur[c]--;
      end
      step(1);
    end
    sum = 1'b1; rest = 1'b1; step(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
